// File: rtl/demux_buf.sv
// ---------------------------------------------------------------------------
// demux_buf : registered 1:2 demultiplexer, one valid/ready FIFO per output
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demux_buf #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in,
  input  logic                       s,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out1,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [WIDTH-1:0]           out2,
  output logic                       out2_valid,
  input  logic                       out2_ready,
  output logic [$clog2(DEPTH):0]     cnt1,
  output logic [$clog2(DEPTH):0]     cnt2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [WIDTH-1:0] w_head  [2];
  logic [CW-1:0]    w_cnt   [2];
  logic [1:0]       w_oready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;

  assign w_oready = {out2_ready, out1_ready};

  // Readiness looks only at the selected channel's registered count, so a
  // full FIFO is never relieved by a same-cycle pop.
  assign in_ready = s ? (w_cnt[1] != c_full) : (w_cnt[0] != c_full);

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;

    assign w_push[k] = in_valid & in_ready & (s == 1'(k));
    assign w_pop[k]  = (r_cnt != '0) & w_oready[k];
    assign w_head[k] = r_mem[r_rd];
    assign w_cnt[k]  = r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else begin
        if (w_push[k]) begin
          r_mem[r_wr] <= in;
          r_wr        <= r_wr + 1'b1;
        end
        if (w_pop[k]) begin
          r_rd <= r_rd + 1'b1;
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign out1       = w_head[0];
  assign out2       = w_head[1];
  assign cnt1       = w_cnt[0];
  assign cnt2       = w_cnt[1];
  assign out1_valid = (w_cnt[0] != '0);
  assign out2_valid = (w_cnt[1] != '0);

endmodule

`default_nettype wire

// File: tb/tb_demux_buf.sv
// ---------------------------------------------------------------------------
// tb_demux_buf : directed and random stimulus against a queue-based model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_demux_buf;
  localparam int W  = 4;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          s;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out1;
  logic          out1_valid;
  logic          out1_ready;
  logic [W-1:0]  out2;
  logic          out2_valid;
  logic          out2_ready;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;

  demux_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .s          (s),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1       (out1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2       (out2),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q1 [$];
  logic [W-1:0] q2 [$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [W-1:0] d,
                       input logic r1, input logic r2);
    in_valid   = v;
    s          = sel;
    din        = d;
    out1_ready = r1;
    out2_ready = r2;
  endtask

  // Compare outputs against the model mid-cycle, then advance one edge.
  task automatic cycle();
    bit er, p1, p2, pu;
    @(negedge clk);
    er = s ? (q2.size() != D) : (q1.size() != D);
    check("in_ready",   in_ready,   er);
    check("cnt1",       cnt1,       q1.size());
    check("cnt2",       cnt2,       q2.size());
    check("out1_valid", out1_valid, q1.size() > 0);
    check("out2_valid", out2_valid, q2.size() > 0);
    if (q1.size() > 0) check("out1", out1, q1[0]);
    if (q2.size() > 0) check("out2", out2, q2[0]);
    p1 = (q1.size() > 0) && out1_ready;
    p2 = (q2.size() > 0) && out2_ready;
    pu = in_valid && er;
    @(posedge clk);
    #1;
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (p1) void'(q1.pop_front());
      if (p2) void'(q2.pop_front());
      if (pu) begin
        if (s) q2.push_back(din);
        else   q1.push_back(din);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, 0, 0);
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("out1_rst", out1, 0);
    check("out2_rst", out2, 0);
    @(posedge clk); #1;

    // single pushes to each channel with sinks ready
    drive(1, 0, 4'h1, 1, 1); cycle();
    drive(1, 1, 4'h0, 1, 1); cycle();
    drive(0, 0, 4'h0, 1, 1); cycle(); cycle(); cycle();

    // channel 1 stalled: fill, overfill, other channel still flows in
    drive(1, 0, 4'h1, 0, 1); cycle();
    drive(1, 0, 4'h0, 0, 1); cycle();
    drive(1, 0, 4'h1, 0, 0); cycle();
    drive(1, 1, 4'h5, 0, 0); cycle();
    drive(1, 0, 4'h1, 1, 1); cycle(); cycle();
    drive(0, 0, 4'h0, 1, 1); cycle(); cycle(); cycle();

    // steady push+pop on channel 1 with one word resident
    drive(1, 0, 4'hA, 0, 1); cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, (i % 2) ? 4'h3 : 4'hC, 1, 1);
      cycle();
    end
    drive(0, 0, 4'h0, 1, 1); cycle(); cycle();

    // fill both, reset mid-stream, nothing queued may reappear
    for (int i = 0; i < 4; i++) begin
      drive(1, i[0], 4'(i + 7), 0, 0);
      cycle();
    end
    rst = 1'b1; drive(1, 0, 4'hF, 1, 1); cycle();
    rst = 1'b0; drive(0, 0, 4'h0, 1, 1); cycle(); cycle(); cycle();

    // random traffic with varying sink pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        drive(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
              ($urandom_range(0, 3) < ph + 1), ($urandom_range(0, 3) < 4 - ph));
        if (ph == 2 && i == 300) rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end
    drive(0, 0, 4'h0, 1, 1); cycle(); cycle(); cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
